// File: rtl/bit_packer_pkg.sv
// Shared types and helpers for the serial-to-parallel bit packer.
package bit_packer_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } state_t;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_packer_out_reg.sv
// Single-entry valid/ready holding register for a packed word and its bit count.
module bit_packer_out_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CW-1:0]    load_count,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_valid,
  output logic             free
);

  // Free when empty or when the current word leaves this cycle.
  assign free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_count <= load_count;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_packer.sv
// Packs a serial bit stream LSB-first into WIDTH-bit words with flush and overflow reporting.
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    stall_count;
  logic [WIDTH-1:0] buffer;

  logic             accept;
  logic             full;
  logic             emit;
  logic             load;
  logic             hold_free;
  logic [WIDTH-1:0] word_next;
  logic [CW-1:0]    cnt_next;
  logic [WIDTH-1:0] load_data;
  logic [CW-1:0]    load_count;

  // Buffer bits at and above cnt are always zero, so a flushed word needs no masking.
  always_comb begin
    accept    = in_valid && (state == FILL);
    word_next = buffer;
    for (int i = 0; i < WIDTH; i++) begin
      if (accept && (cnt == CW'(i))) word_next[i] = in_bit;
    end
    cnt_next   = cnt + CW'(accept);
    full       = accept && (cnt == CW'(WIDTH - 1));
    emit       = (state == FILL) && (full || (flush && (cnt_next != '0)));
    load       = ((state == STALL) || emit) && hold_free;
    load_data  = (state == STALL) ? buffer : word_next;
    load_count = (state == STALL) ? stall_count : cnt_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      cnt         <= '0;
      stall_count <= '0;
      buffer      <= '0;
      overflow    <= 1'b0;
    end else begin
      overflow <= in_valid && (state == STALL);
      unique case (state)
        FILL: begin
          if (emit) begin
            cnt <= '0;
            if (hold_free) begin
              buffer <= '0;
            end else begin
              buffer      <= word_next;
              stall_count <= cnt_next;
              state       <= STALL;
            end
          end else begin
            buffer <= word_next;
            cnt    <= cnt_next;
          end
        end
        STALL: begin
          if (hold_free) begin
            buffer <= '0;
            state  <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  bit_packer_out_reg #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .load_count(load_count),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .free      (hold_free)
  );

endmodule

// File: tb/tb_bit_packer.sv
// Directed-vector bench for bit_packer at WIDTH=8.
module tb_bit_packer;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_bit;
  logic             in_valid;
  logic             flush;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_count;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;

  int n_vec = 0;
  int n_bad = 0;

  bit_packer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .flush    (flush),
    .out_data (out_data),
    .out_count(out_count),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fl);
    in_bit   = b;
    in_valid = 1'b1;
    flush    = fl;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    tick();
  endtask

  logic [7:0] pat;
  logic       early;
  logic       ov_seen;

  initial begin
    reset = 1'b1; in_bit = 1'b1; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; in_bit = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_count", 32'(out_count), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    idle();
    chk("rst_no_word", 32'(out_valid), 32'h0);

    // Basic word 1,0,1,1,0,0,1,0 -> 8'h4D
    pat = 8'h4D; early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(pat[i], 1'b0);
      if (i < 7) early |= out_valid;
    end
    chk("w1_early", 32'(early), 32'h0);
    chk("w1_valid", 32'(out_valid), 32'h1);
    chk("w1_data", 32'(out_data), 32'h4D);
    chk("w1_count", 32'(out_count), 32'h8);
    idle();
    chk("w1_single", 32'(out_valid), 32'h0);

    // 16 continuous bits: 0xA5 then 0x3C
    ov_seen = 1'b0; early = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pat = (i < 8) ? 8'hA5 : 8'h3C;
      send_bit(pat[i % 8], 1'b0);
      ov_seen |= overflow;
      if (i == 7) begin
        chk("s16_valid_a", 32'(out_valid), 32'h1);
        chk("s16_data_a", 32'(out_data), 32'hA5);
      end else if (i == 15) begin
        chk("s16_valid_b", 32'(out_valid), 32'h1);
        chk("s16_data_b", 32'(out_data), 32'h3C);
      end else begin
        early |= out_valid;
      end
    end
    chk("s16_gap", 32'(early), 32'h0);
    chk("s16_ovf", 32'(ov_seen), 32'h0);
    idle();

    // Backpressure: hold 0x96, fill 0x71 into the buffer, drop the 17th bit
    out_ready = 1'b0;
    pat = 8'h96;
    for (int i = 0; i < 8; i++) send_bit(pat[i], 1'b0);
    chk("bp_valid_a", 32'(out_valid), 32'h1);
    chk("bp_data_a", 32'(out_data), 32'h96);
    pat = 8'h71; ov_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(pat[i], 1'b0);
      ov_seen |= overflow;
    end
    chk("bp_hold_data", 32'(out_data), 32'h96);
    chk("bp_hold_valid", 32'(out_valid), 32'h1);
    chk("bp_no_ovf", 32'(ov_seen), 32'h0);
    send_bit(1'b1, 1'b0);
    chk("bp_ovf", 32'(overflow), 32'h1);
    send_bit(1'b0, 1'b1);
    chk("bp_ovf_2", 32'(overflow), 32'h1);
    idle();
    chk("bp_ovf_clr", 32'(overflow), 32'h0);
    chk("bp_stable", 32'(out_data), 32'h96);
    out_ready = 1'b1;
    idle();
    chk("bp_valid_b", 32'(out_valid), 32'h1);
    chk("bp_data_b", 32'(out_data), 32'h71);
    chk("bp_count_b", 32'(out_count), 32'h8);
    idle();
    chk("bp_drain", 32'(out_valid), 32'h0);

    // Partial flush: 1,1,0 -> 8'h03, count 3; empty flush does nothing
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("pf_not_yet", 32'(out_valid), 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pf_valid", 32'(out_valid), 32'h1);
    chk("pf_data", 32'(out_data), 32'h03);
    chk("pf_count", 32'(out_count), 32'h3);
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ef_none", 32'(out_valid), 32'h0);
    idle();
    chk("ef_none_2", 32'(out_valid), 32'h0);

    // Flush together with a bit: 1,0,1 with flush on the third -> 8'h05, count 3
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("fb_data", 32'(out_data), 32'h05);
    chk("fb_count", 32'(out_count), 32'h3);
    idle();

    // Flush with the 8th bit -> one full word only
    pat = 8'hC3;
    for (int i = 0; i < 8; i++) send_bit(pat[i], (i == 7) ? 1'b1 : 1'b0);
    chk("f8_valid", 32'(out_valid), 32'h1);
    chk("f8_data", 32'(out_data), 32'hC3);
    chk("f8_count", 32'(out_count), 32'h8);
    idle();
    chk("f8_no_extra", 32'(out_valid), 32'h0);
    idle();
    chk("f8_no_extra_2", 32'(out_valid), 32'h0);

    // Reset after 5 bits discards them
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    chk("mr_valid", 32'(out_valid), 32'h0);
    pat = 8'h5A; early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(pat[i], 1'b0);
      if (i < 7) early |= out_valid;
    end
    chk("mr_early", 32'(early), 32'h0);
    chk("mr_data", 32'(out_data), 32'h5A);
    chk("mr_count", 32'(out_count), 32'h8);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
